systolic_drain: RTL and testbench
=================================

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter SYSTOLIC_WIDTH, default 4, meaning array columns (W).
REQ-002 SHALL have parameter SUM_WIDTH, default 16, meaning bits per partial-sum column.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning result rows buffered; must be a power of two and at least 2.
REQ-004 SHALL have ports as follows (clock and reset first; reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a job.
- row_count  in  16  result rows expected; sampled on accepted start.
- sum_in  in  W*SUM_WIDTH  skewed array bottom-row sums; column k in bits [k*SUM_WIDTH +: SUM_WIDTH].
- in_valid  in  1  column 0 of a row is valid this cycle; column k of that row is valid k cycles later.
- m_data  out  W*SUM_WIDTH  deskewed result row, same column packing as sum_in.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts m_data.
- almost_full  out  1  FIFO occupancy >= FIFO_DEPTH-W; upstream must stall.
- busy  out  1  FSM is not IDLE.
- done  out  1  one-cycle pulse at job completion.
- overflow  out  1  sticky: a deskewed row was dropped because the FIFO was full.
- err_clr  in  1  clears overflow.

Function
REQ-005 SHALL implement FSM states IDLE, COLLECT and DRAIN.
REQ-006 IDLE->COLLECT on start with row_count!=0; start with row_count==0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-007 start SHALL be ignored in COLLECT and DRAIN.
REQ-008 in_valid SHALL be accepted only in COLLECT while issued_cnt<row_count; each acceptance increments issued_cnt; all other in_valid pulses are ignored.
REQ-009 Deskew: column k SHALL be delayed W-1-k cycles, so column W-1 passes with no delay; the accepted valid SHALL be delayed W-1 cycles with it.
REQ-010 Row data SHALL be captured bit-exact; no arithmetic is performed.
REQ-011 A deskewed valid row SHALL be written to the FIFO; captured_cnt increments on every deskewed valid, including dropped rows.
REQ-012 COLLECT->DRAIN when captured_cnt reaches row_count.
REQ-013 DRAIN->IDLE when the FIFO is empty, with done pulsed the cycle after the last m_valid&&m_ready handshake.
REQ-014 Latency: in_valid at cycle t with an empty FIFO and m_ready=1 SHALL give m_valid at t+W.
REQ-015 m_valid/m_data SHALL be registered FIFO head outputs, and m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-016 A simultaneous push and pop when full SHALL succeed with no drop; a push when full without a pop SHALL drop the row and set overflow.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH, with occupancy tracked by a count 0..FIFO_DEPTH.
REQ-018 almost_full SHALL be combinational from occupancy.
REQ-019 overflow SHALL stay set until err_clr; if err_clr and a new drop occur in the same cycle, overflow SHALL remain 1.

Reset
REQ-020 On rst_n low, SHALL go to IDLE; clear counters, pointers and deskew registers; and drive m_valid=0, m_data=0, busy=0, done=0, overflow=0.
REQ-021 Reset mid-job SHALL discard all buffered and in-flight rows, with no done pulse.

Structure
REQ-022 The FSM state enum and the counter width constant (16) SHALL live in shared package systolic_pkg.
REQ-023 The deskew lines SHALL reuse the existing delay_reg sub-module: per column k<W-1, DELAY_CYCLES=W-1-k with delay_switch=1; column W-1 is a bypass.
REQ-024 The FIFO SHALL be inline; no further sub-modules.

Verification (W=4, SUM_WIDTH=16, FIFO_DEPTH=8)
REQ-025 Skew alignment: start, row_count=1; in_valid at cycle 0; column k=0x1000+k at cycle k; m_ready=1 -> m_valid at cycle 4 with m_data={0x1003,0x1002,0x1001,0x1000}, then done one cycle later.
REQ-026 Streaming: row_count=5, in_valid on 5 consecutive cycles, m_ready=1 -> 5 back-to-back rows in order, busy high throughout, a single done pulse.
REQ-027 Backpressure: row_count=10, m_ready=0 -> almost_full=1 at occupancy 4, all 8 rows held, 2 rows dropped and overflow=1; after err_clr, overflow=0.
REQ-028 Full with pop: FIFO full and m_ready=1 while a row is pushed -> no drop, occupancy stays 8, overflow stays 0.
REQ-029 Boundaries: start with row_count=0 -> done at cycle+1 and busy stays 0; 3 in_valid pulses after row_count=2 -> only 2 rows output; start during COLLECT -> ignored.
REQ-030 Reset mid-job: rst_n low after 2 of 4 rows -> m_valid=0, busy=0, no done; a new job after reset completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result drain path.
package systolic_pkg;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/delay_reg.sv
// Fixed-length register delay line; delay_switch=0 passes din straight through.
module delay_reg #(
    parameter int WIDTH        = 1,
    parameter int DELAY_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             delay_switch,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [DELAY_CYCLES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY_CYCLES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DELAY_CYCLES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = delay_switch ? stage_reg[DELAY_CYCLES-1] : din;

endmodule

// File: rtl/systolic_drain.sv
// Deskews the systolic array bottom-row sums into whole rows and buffers them
// in a FIFO whose head is a register feeding m_data/m_valid.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int SUM_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [CNT_WIDTH-1:0]                row_count,
    input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] sum_in,
    input  logic                                in_valid,
    output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic                                almost_full,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow,
    input  logic                                err_clr
);

    localparam int W     = SYSTOLIC_WIDTH;
    localparam int ROW_W = W * SUM_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'((FIFO_DEPTH > W) ? (FIFO_DEPTH - W) : 0);

    drain_state_e state_reg, state_next;
    logic         done_reg, done_next;
    logic         load_job;

    logic [CNT_WIDTH-1:0] row_cnt_reg;
    logic [CNT_WIDTH-1:0] issued_cnt_reg;
    logic [CNT_WIDTH-1:0] captured_cnt_reg;

    logic             accept;
    logic             deskew_valid;
    logic [ROW_W-1:0] deskew_row;

    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             m_valid_reg;
    logic [ROW_W-1:0] m_data_reg;
    logic             overflow_reg;

    logic pop, push_ok, drop, mem_empty, head_free, bypass, mem_wr, head_from_mem;

    assign accept = (state_reg == COLLECT) && in_valid && (issued_cnt_reg < row_cnt_reg);

    // Column k arrives k cycles after its row's valid; delaying it W-1-k cycles
    // lines every column up with the valid delayed by W-1.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_col
            if (gi < W - 1) begin : g_dly
                delay_reg #(
                    .WIDTH        (SUM_WIDTH),
                    .DELAY_CYCLES (W - 1 - gi)
                ) u_col_dly (
                    .clk          (clk),
                    .rst_n        (rst_n),
                    .delay_switch (1'b1),
                    .din          (sum_in[gi*SUM_WIDTH +: SUM_WIDTH]),
                    .dout         (deskew_row[gi*SUM_WIDTH +: SUM_WIDTH])
                );
            end else begin : g_bypass
                assign deskew_row[gi*SUM_WIDTH +: SUM_WIDTH] = sum_in[gi*SUM_WIDTH +: SUM_WIDTH];
            end
        end

        if (W > 1) begin : g_vld_dly
            delay_reg #(
                .WIDTH        (1),
                .DELAY_CYCLES (W - 1)
            ) u_vld_dly (
                .clk          (clk),
                .rst_n        (rst_n),
                .delay_switch (1'b1),
                .din          (accept),
                .dout         (deskew_valid)
            );
        end else begin : g_vld_bypass
            assign deskew_valid = accept;
        end
    endgenerate

    // count_reg covers the head register plus the rows still in mem.
    assign pop           = m_valid_reg && m_ready;
    assign push_ok       = deskew_valid && ((count_reg != FULL_LEVEL) || pop);
    assign drop          = deskew_valid && !push_ok;
    assign mem_empty     = (count_reg == CNT_W'(m_valid_reg));
    assign head_free     = !m_valid_reg || pop;
    assign head_from_mem = head_free && !mem_empty;
    assign bypass        = head_free && mem_empty && push_ok;
    assign mem_wr        = push_ok && !bypass;
    assign count_next    = count_reg + CNT_W'(push_ok) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= deskew_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (head_from_mem) begin
                m_data_reg  <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                m_valid_reg <= 1'b1;
            end else if (bypass) begin
                m_data_reg  <= deskew_row;
                m_valid_reg <= 1'b1;
            end else if (pop) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    // A drop wins over err_clr so a fresh loss is never hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (err_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_reg      <= '0;
            issued_cnt_reg   <= '0;
            captured_cnt_reg <= '0;
        end else if (load_job) begin
            row_cnt_reg      <= row_count;
            issued_cnt_reg   <= '0;
            captured_cnt_reg <= '0;
        end else begin
            if (accept) begin
                issued_cnt_reg <= issued_cnt_reg + 1'b1;
            end
            if (deskew_valid) begin
                captured_cnt_reg <= captured_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    // Transitions look at count_next so done lands the cycle after the final pop.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        load_job   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (row_count != '0) begin
                        state_next = COLLECT;
                        load_job   = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (deskew_valid && ((captured_cnt_reg + 1'b1) == row_cnt_reg)) begin
                    if (count_next == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_data      = m_data_reg;
    assign m_valid     = m_valid_reg;
    assign almost_full = (count_reg >= AF_LEVEL);
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: stimulus queues expected rows, a negedge
// monitor pops and compares them whenever a row is handed off.
module tb_systolic_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] row_count;
    logic [63:0] sum_in;
    logic        in_valid;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        almost_full;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        err_clr;

    systolic_drain #(
        .SYSTOLIC_WIDTH (4),
        .SUM_WIDTH      (16),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .row_count   (row_count),
        .sum_in      (sum_in),
        .in_valid    (in_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .almost_full (almost_full),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    int hs_count, first_hs_cyc, last_hs_cyc, done_cnt, last_done_cyc, af_rise_cyc, busy_drop;
    int t0;
    logic track_busy = 1'b0;
    logic prev_hold = 1'b0;
    logic [63:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] colv(input logic [15:0] base, input int r, input int k);
        return base + 16'(r * 16 + k);
    endfunction

    function automatic logic [63:0] exp_row(input logic [15:0] base, input int r);
        logic [63:0] row;
        for (int k = 0; k < 4; k++) row[k*16 +: 16] = colv(base, r, k);
        return row;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_stats();
        hs_count = 0; first_hs_cyc = -1; last_hs_cyc = -1;
        done_cnt = 0; last_done_cyc = -1; af_rise_cyc = -1; busy_drop = 0;
    endtask

    task automatic start_job(input logic [15:0] rc);
        start = 1'b1;
        row_count = rc;
        tick();
        start = 1'b0;
        track_busy = 1'b1;
    endtask

    task automatic push_rows(input logic [15:0] base, input int n);
        for (int r = 0; r < n; r++) exp_q.push_back(exp_row(base, r));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        track_busy = 1'b0;
        check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    // Drives rows with column k of row r at relative cycle r+k.
    task automatic stream(input int n_valid, input int n_rows, input logic [15:0] base, input int ncyc,
                          input int err_cyc, input int ready_cyc, input int start_cyc);
        t0 = cyc;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = (c < n_valid);
            for (int k = 0; k < 4; k++) begin
                int r;
                r = c - k;
                sum_in[k*16 +: 16] = (r >= 0 && r < n_rows) ? colv(base, r, k) : 16'h0;
            end
            err_clr = (c == err_cyc);
            if (c == ready_cyc) m_ready = 1'b1;
            start = (c == start_cyc);
            if (c == start_cyc) row_count = 16'd7;
            tick();
        end
        in_valid = 1'b0;
        sum_in = '0;
        err_clr = 1'b0;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (almost_full && af_rise_cyc < 0) af_rise_cyc = cyc;
        if (track_busy && !busy) busy_drop++;
        if (prev_hold && m_valid) check("hold_stable", m_data, prev_data);
        if (m_valid && m_ready) begin
            hs_count++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row: got %0h expected none (cycle %0d)", m_data, cyc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                $display("row out cycle %0d data %h", cyc, m_data);
                check("row_data", m_data, e);
            end
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; row_count = '0; sum_in = '0;
        in_valid = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        reset_stats();
        tick(); tick();
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_almost_full", {63'd0, almost_full}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Skew alignment, single row
        reset_stats(); m_ready = 1'b1;
        start_job(16'd1);
        push_rows(16'h1000, 1);
        stream(1, 1, 16'h1000, 4, -1, -1, -1);
        wait_idle(50); tick(); tick();
        check("t1_latency", 64'(first_hs_cyc), 64'(t0 + 4));
        check("t1_done_cycle", 64'(last_done_cyc), 64'(t0 + 5));
        check("t1_done_count", 64'(done_cnt), 64'd1);

        // Streaming, 5 back-to-back rows
        reset_stats();
        start_job(16'd5);
        push_rows(16'h2000, 5);
        stream(5, 5, 16'h2000, 8, -1, -1, -1);
        wait_idle(50); tick(); tick();
        check("t2_rows", 64'(hs_count), 64'd5);
        check("t2_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'd4);
        check("t2_busy_gaps", 64'(busy_drop), 64'd0);
        check("t2_done_count", 64'(done_cnt), 64'd1);

        // Backpressure: 10 rows into an 8-deep FIFO, err_clr during the second drop
        reset_stats(); m_ready = 1'b0;
        start_job(16'd10);
        push_rows(16'h3000, 8);
        stream(10, 10, 16'h3000, 14, 12, -1, -1);
        check("t3_af_rise", 64'(af_rise_cyc), 64'(t0 + 7));
        check("t3_overflow", {63'd0, overflow}, 64'd1);
        check("t3_almost_full", {63'd0, almost_full}, 64'd1);
        check("t3_held_valid", {63'd0, m_valid}, 64'd1);
        check("t3_no_handshake", 64'(hs_count), 64'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t3_err_clr", {63'd0, overflow}, 64'd0);
        m_ready = 1'b1;
        wait_idle(100); tick(); tick();
        check("t3_rows", 64'(hs_count), 64'd8);
        check("t3_done_count", 64'(done_cnt), 64'd1);

        // Full FIFO with a simultaneous pop and push
        reset_stats(); m_ready = 1'b0;
        start_job(16'd9);
        push_rows(16'h4000, 9);
        stream(9, 9, 16'h4000, 12, -1, 11, -1);
        check("t4_af_full", {63'd0, almost_full}, 64'd1);
        check("t4_no_overflow", {63'd0, overflow}, 64'd0);
        wait_idle(100); tick(); tick();
        check("t4_rows", 64'(hs_count), 64'd9);
        check("t4_overflow_end", {63'd0, overflow}, 64'd0);

        // row_count == 0
        reset_stats();
        start = 1'b1; row_count = 16'd0; tick(); start = 1'b0;
        check("t5a_done", {63'd0, done}, 64'd1);
        check("t5a_busy", {63'd0, busy}, 64'd0);
        tick();
        check("t5a_done_pulse", {63'd0, done}, 64'd0);
        check("t5a_done_count", 64'(done_cnt), 64'd1);

        // Three in_valid pulses against row_count=2
        reset_stats(); m_ready = 1'b1;
        start_job(16'd2);
        push_rows(16'h5000, 2);
        stream(3, 3, 16'h5000, 6, -1, -1, -1);
        wait_idle(50); tick(); tick();
        check("t5b_rows", 64'(hs_count), 64'd2);

        // start during COLLECT is ignored
        reset_stats();
        start_job(16'd2);
        push_rows(16'h5800, 2);
        stream(2, 2, 16'h5800, 5, -1, -1, 1);
        wait_idle(50); tick(); tick();
        check("t5c_rows", 64'(hs_count), 64'd2);
        check("t5c_done_count", 64'(done_cnt), 64'd1);
        check("t5c_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a job
        reset_stats();
        start_job(16'd4);
        stream(2, 2, 16'h6000, 2, -1, -1, -1);
        rst_n = 1'b0; track_busy = 1'b0;
        #1;
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        check("t6_rst_m_valid", {63'd0, m_valid}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_done", 64'(done_cnt), 64'd0);
        check("t6_no_rows", 64'(hs_count), 64'd0);
        start_job(16'd1);
        push_rows(16'h7000, 1);
        stream(1, 1, 16'h7000, 4, -1, -1, -1);
        wait_idle(50); tick(); tick();
        check("t6_new_rows", 64'(hs_count), 64'd1);
        check("t6_new_done", 64'(done_cnt), 64'd1);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
